// File: rtl/xgmii_pkg.sv
// rtl/xgmii_pkg.sv - XGMII control codes, fixed framing words and transmit state encoding.
package xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE     = 8'h07;
    localparam logic [7:0] XGMII_START    = 8'hFB;
    localparam logic [7:0] XGMII_TERM     = 8'hFD;
    localparam logic [7:0] XGMII_ERROR    = 8'hFE;
    localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
    localparam logic [7:0] XGMII_SFD      = 8'hD5;

    localparam logic [63:0] IDLE_WORD     = {8{XGMII_IDLE}};
    localparam logic [7:0]  IDLE_TXC      = 8'hFF;
    localparam logic [63:0] PREAMBLE_WORD = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};
    localparam logic [7:0]  PREAMBLE_TXC  = 8'h01;
    localparam logic [63:0] ERROR_WORD    = {8{XGMII_ERROR}};
    localparam logic [7:0]  ERROR_TXC     = 8'hFF;
    localparam logic [63:0] TERM_WORD     = {{7{XGMII_IDLE}}, XGMII_TERM};
    localparam logic [7:0]  TERM_TXC      = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_TERM  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_IFG   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/xgmii_term_insert.sv
// rtl/xgmii_term_insert.sv - Merges data lanes, terminate code and trailing idles for a frame's last word.
module xgmii_term_insert
    import xgmii_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [2:0]  bytes_i,
    output logic [63:0] txd_o,
    output logic [7:0]  txc_o
);

    // bytes_i == 0 means all eight lanes carry data; the terminate goes in a following word.
    always_comb begin
        txd_o = data_i;
        txc_o = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (bytes_i != 3'd0) begin
                if (k == int'(bytes_i)) begin
                    txd_o[8*k +: 8] = XGMII_TERM;
                    txc_o[k]        = 1'b1;
                end else if (k > int'(bytes_i)) begin
                    txd_o[8*k +: 8] = XGMII_IDLE;
                    txc_o[k]        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/xgmii_tx_framer.sv
// rtl/xgmii_tx_framer.sv - XGMII transmit framer; XGMII_TX_FRAMER_STATS_EN adds frame/underrun counters.
module xgmii_tx_framer
    import xgmii_pkg::*;
#(
    parameter int unsigned IFG_WORDS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        link_up,
    input  logic [63:0] frame_data,
    input  logic [2:0]  frame_bytes,
    input  logic        frame_last,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic        tx_busy,
`ifdef XGMII_TX_FRAMER_STATS_EN
    output logic [31:0] tx_frame_count,
    output logic [31:0] tx_underrun_count,
`endif
    output logic        underrun
);

    localparam logic [3:0] IFG_LOAD = 4'(IFG_WORDS);

    tx_state_t   state_q;
    logic [63:0] txd_q;
    logic [7:0]  txc_q;
    logic        underrun_q;
    logic [3:0]  ifg_cnt_q;
    logic [63:0] term_txd;
    logic [7:0]  term_txc;

`ifdef XGMII_TX_FRAMER_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [31:0] underrun_cnt_q;
    assign tx_frame_count    = frame_cnt_q;
    assign tx_underrun_count = underrun_cnt_q;
`endif

    xgmii_term_insert u_term_insert (
        .data_i  (frame_data),
        .bytes_i (frame_bytes),
        .txd_o   (term_txd),
        .txc_o   (term_txc)
    );

    assign frame_ready = (state_q == ST_DATA) || (state_q == ST_DRAIN);
    assign tx_busy     = (state_q != ST_IDLE);
    assign xgmii_txd   = txd_q;
    assign xgmii_txc   = txc_q;
    assign underrun    = underrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            txd_q      <= IDLE_WORD;
            txc_q      <= IDLE_TXC;
            underrun_q <= 1'b0;
            ifg_cnt_q  <= 4'd0;
`ifdef XGMII_TX_FRAMER_STATS_EN
            frame_cnt_q    <= 32'd0;
            underrun_cnt_q <= 32'd0;
`endif
        end else begin
            underrun_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    txd_q <= IDLE_WORD;
                    txc_q <= IDLE_TXC;
                    // The waiting word is not consumed; it is accepted from DATA next cycle.
                    if (link_up && frame_valid) begin
                        txd_q   <= PREAMBLE_WORD;
                        txc_q   <= PREAMBLE_TXC;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!frame_valid) begin
                        txd_q      <= ERROR_WORD;
                        txc_q      <= ERROR_TXC;
                        underrun_q <= 1'b1;
                        state_q    <= ST_DRAIN;
`ifdef XGMII_TX_FRAMER_STATS_EN
                        underrun_cnt_q <= underrun_cnt_q + 32'd1;
`endif
                    end else if (frame_last && frame_bytes != 3'd0) begin
                        txd_q     <= term_txd;
                        txc_q     <= term_txc;
                        ifg_cnt_q <= IFG_LOAD;
                        state_q   <= ST_IFG;
`ifdef XGMII_TX_FRAMER_STATS_EN
                        frame_cnt_q <= frame_cnt_q + 32'd1;
`endif
                    end else begin
                        txd_q <= frame_data;
                        txc_q <= 8'h00;
                        if (frame_last) begin
                            state_q <= ST_TERM;
                        end
                    end
                end
                ST_TERM: begin
                    txd_q     <= TERM_WORD;
                    txc_q     <= TERM_TXC;
                    ifg_cnt_q <= IFG_LOAD;
                    state_q   <= ST_IFG;
`ifdef XGMII_TX_FRAMER_STATS_EN
                    frame_cnt_q <= frame_cnt_q + 32'd1;
`endif
                end
                ST_DRAIN: begin
                    txd_q <= IDLE_WORD;
                    txc_q <= IDLE_TXC;
                    if (frame_valid && frame_last) begin
                        ifg_cnt_q <= IFG_LOAD;
                        state_q   <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    txd_q     <= IDLE_WORD;
                    txc_q     <= IDLE_TXC;
                    ifg_cnt_q <= ifg_cnt_q - 4'd1;
                    if (ifg_cnt_q <= 4'd1) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    txd_q   <= IDLE_WORD;
                    txc_q   <= IDLE_TXC;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// tb/tb_xgmii_tx_framer.sv - Directed self-checking bench for xgmii_tx_framer.
module tb_xgmii_tx_framer;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
    localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] TERM_W = 64'h07070707070707FD;

    logic        clk = 1'b0;
    logic        reset;
    logic        link_up;
    logic [63:0] frame_data;
    logic [2:0]  frame_bytes;
    logic        frame_last;
    logic        frame_valid;
    logic        frame_ready;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        tx_busy;
    logic        underrun;
`ifdef XGMII_TX_FRAMER_STATS_EN
    logic [31:0] tx_frame_count;
    logic [31:0] tx_underrun_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xgmii_tx_framer #(.IFG_WORDS(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .link_up     (link_up),
        .frame_data  (frame_data),
        .frame_bytes (frame_bytes),
        .frame_last  (frame_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .xgmii_txd   (xgmii_txd),
        .xgmii_txc   (xgmii_txc),
        .tx_busy     (tx_busy),
`ifdef XGMII_TX_FRAMER_STATS_EN
        .tx_frame_count    (tx_frame_count),
        .tx_underrun_count (tx_underrun_count),
`endif
        .underrun    (underrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic l, input logic [2:0] b);
        frame_valid = v;
        frame_data  = d;
        frame_last  = l;
        frame_bytes = b;
    endtask

    task automatic test_reset();
        reset = 1'b1; link_up = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 3'd0);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF || frame_ready !== 1'b0 ||
                tx_busy !== 1'b0 || underrun !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: txd=%h txc=%h rdy=%b busy=%b urun=%b, want %h FF 0 0 0",
                         i, xgmii_txd, xgmii_txc, frame_ready, tx_busy, underrun, IDLE_W);
            end
        end
    endtask

    task automatic test_link_gate();
        link_up = 1'b0;
        drive(1'b1, 64'h0123456789ABCDEF, 1'b0, 3'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF || frame_ready !== 1'b0) begin
                errors++;
                $display("FAIL link_gate cyc%0d: txd=%h txc=%h rdy=%b, want idle, rdy 0",
                         i, xgmii_txd, xgmii_txc, frame_ready);
            end
        end
        link_up = 1'b1;
        tick();
        checks++;
        if (xgmii_txd !== PRE_W || xgmii_txc !== 8'h01 || frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL link_preamble: txd=%h txc=%h rdy=%b, want %h 01 1", xgmii_txd, xgmii_txc, frame_ready, PRE_W);
        end
    endtask

    // Entered with the preamble on the bus and 0x0123456789ABCDEF presented as word 1.
    task automatic test_partial_last();
        tick();
        checks++;
        if (xgmii_txd !== 64'h0123456789ABCDEF || xgmii_txc !== 8'h00) begin
            errors++;
            $display("FAIL p_word1: txd=%h txc=%h, want 0123456789abcdef 00", xgmii_txd, xgmii_txc);
        end
        drive(1'b1, 64'hCAFEF00DDEADBEEF, 1'b0, 3'd0);
        tick();
        checks++;
        if (xgmii_txd !== 64'hCAFEF00DDEADBEEF || xgmii_txc !== 8'h00) begin
            errors++;
            $display("FAIL p_word2: txd=%h txc=%h, want cafef00ddeadbeef 00", xgmii_txd, xgmii_txc);
        end
        drive(1'b1, 64'h1122334455667788, 1'b1, 3'd3);
        tick();
        checks++;
        if (xgmii_txd !== 64'h07070707FD667788 || xgmii_txc !== 8'hF8 || frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL p_term: txd=%h txc=%h rdy=%b, want 07070707fd667788 f8 0", xgmii_txd, xgmii_txc, frame_ready);
        end
        drive(1'b1, 64'hA1A2A3A4A5A6A7A8, 1'b0, 3'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF || frame_ready !== 1'b0) begin
                errors++;
                $display("FAIL p_ifg%0d: txd=%h txc=%h rdy=%b, want idle", i, xgmii_txd, xgmii_txc, frame_ready);
            end
        end
        tick();
        checks++;
        if (xgmii_txd !== PRE_W || xgmii_txc !== 8'h01) begin
            errors++;
            $display("FAIL b2b_preamble: txd=%h txc=%h, want %h 01", xgmii_txd, xgmii_txc, PRE_W);
        end
    endtask

    task automatic test_full_last();
        tick();
        checks++;
        if (xgmii_txd !== 64'hA1A2A3A4A5A6A7A8 || xgmii_txc !== 8'h00) begin
            errors++;
            $display("FAIL f_word1: txd=%h txc=%h, want a1a2a3a4a5a6a7a8 00", xgmii_txd, xgmii_txc);
        end
        drive(1'b1, 64'hB1B2B3B4B5B6B7B8, 1'b1, 3'd0);
        tick();
        checks++;
        if (xgmii_txd !== 64'hB1B2B3B4B5B6B7B8 || xgmii_txc !== 8'h00 || frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL f_word2: txd=%h txc=%h rdy=%b, want b1b2b3b4b5b6b7b8 00 0", xgmii_txd, xgmii_txc, frame_ready);
        end
        drive(1'b0, 64'h0, 1'b0, 3'd0);
        tick();
        checks++;
        if (xgmii_txd !== TERM_W || xgmii_txc !== 8'hFF) begin
            errors++;
            $display("FAIL f_term: txd=%h txc=%h, want %h ff", xgmii_txd, xgmii_txc, TERM_W);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF) begin
                errors++;
                $display("FAIL f_idle%0d: txd=%h txc=%h, want idle", i, xgmii_txd, xgmii_txc);
            end
        end
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL f_busy: busy=%b, want 0", tx_busy);
        end
    endtask

    task automatic test_underrun();
        drive(1'b1, 64'h1111111111111111, 1'b0, 3'd0);
        tick();
        tick();
        checks++;
        if (xgmii_txd !== 64'h1111111111111111 || xgmii_txc !== 8'h00) begin
            errors++;
            $display("FAIL u_word1: txd=%h txc=%h, want 1111111111111111 00", xgmii_txd, xgmii_txc);
        end
        drive(1'b0, 64'h0, 1'b0, 3'd0);
        tick();
        checks++;
        if (xgmii_txd !== ERR_W || xgmii_txc !== 8'hFF || underrun !== 1'b1 || frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL u_error: txd=%h txc=%h urun=%b rdy=%b, want %h ff 1 1",
                     xgmii_txd, xgmii_txc, underrun, frame_ready, ERR_W);
        end
        tick();
        checks++;
        if (underrun !== 1'b0 || xgmii_txd !== IDLE_W) begin
            errors++;
            $display("FAIL u_pulse: urun=%b txd=%h, want 0 idle", underrun, xgmii_txd);
        end
        drive(1'b1, 64'h2222222222222222, 1'b0, 3'd0);
        tick();
        checks++;
        if (xgmii_txd !== IDLE_W || frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL u_drain: txd=%h rdy=%b, want idle 1", xgmii_txd, frame_ready);
        end
        drive(1'b1, 64'h3333333333333333, 1'b1, 3'd4);
        tick();
        checks++;
        if (xgmii_txd !== IDLE_W || frame_ready !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL u_drain_last: txd=%h rdy=%b busy=%b, want idle 0 1", xgmii_txd, frame_ready, tx_busy);
        end
        drive(1'b0, 64'h0, 1'b0, 3'd0);
        tick();
        tick();
        checks++;
        if (xgmii_txd !== IDLE_W || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL u_ifg_done: txd=%h busy=%b, want idle 0", xgmii_txd, tx_busy);
        end
`ifdef XGMII_TX_FRAMER_STATS_EN
        checks++;
        if (tx_frame_count !== 32'd2 || tx_underrun_count !== 32'd1) begin
            errors++;
            $display("FAIL stats: frames=%0d underruns=%0d, want 2 1", tx_frame_count, tx_underrun_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 64'h4444444444444444, 1'b0, 3'd0);
        tick();
        tick();
        drive(1'b1, 64'h5555555555555555, 1'b1, 3'd2);
        reset = 1'b1;
        tick();
        checks++;
        if (xgmii_txd !== IDLE_W || xgmii_txc !== 8'hFF || tx_busy !== 1'b0 || frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: txd=%h txc=%h busy=%b rdy=%b, want idle ff 0 0",
                     xgmii_txd, xgmii_txc, tx_busy, frame_ready);
        end
        reset = 1'b0;
        drive(1'b1, 64'h0123456789ABCDEF, 1'b1, 3'd1);
        tick();
        checks++;
        if (xgmii_txd !== PRE_W || xgmii_txc !== 8'h01) begin
            errors++;
            $display("FAIL rst_restart: txd=%h txc=%h, want %h 01", xgmii_txd, xgmii_txc, PRE_W);
        end
        tick();
        checks++;
        if (xgmii_txd !== 64'h070707070707FDEF || xgmii_txc !== 8'hFE) begin
            errors++;
            $display("FAIL single_word: txd=%h txc=%h, want 070707070707fdef fe", xgmii_txd, xgmii_txc);
        end
        drive(1'b0, 64'h0, 1'b0, 3'd0);
        tick();
        tick();
        tick();
        checks++;
        if (xgmii_txd !== IDLE_W || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: txd=%h busy=%b, want idle 0", xgmii_txd, tx_busy);
        end
`ifdef XGMII_TX_FRAMER_STATS_EN
        checks++;
        if (tx_frame_count !== 32'd1 || tx_underrun_count !== 32'd0) begin
            errors++;
            $display("FAIL stats_after_reset: frames=%0d underruns=%0d, want 1 0", tx_frame_count, tx_underrun_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_link_gate();
        test_partial_last();
        test_full_last();
        test_underrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
